// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap sequencer beside EX: CSR read-modify-write, interrupt entry, MRET and WFI.
// Optional cycle/instret counters are built when CSR_COUNTER_EN is defined.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_ADDR = 32'h0001_0000,
  parameter int          IRQ_SYNC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic        csr_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [4:0]  zimm_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        wfi_stall_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WFI_WAIT = 2'd1,
    ST_REDIR    = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mstatus_mie, r_mpie, r_meie, r_mtie;
  logic [31:0] r_mepc, r_mcause, r_wfi_pc, r_redirect_pc;

  logic        w_meip, w_mtip;
  logic        w_irq_ext, w_irq_pend, w_take;
  logic [31:0] w_rdata, w_src, w_wdata;
  logic        w_wr_req;
  logic        w_trap, w_mret, w_wfi_enter, w_csr_commit;
  logic [31:0] w_trap_pc;

  generate
    if (IRQ_SYNC >= 2) begin : g_sync2
      logic [1:0] r_ext_s, r_tmr_s;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_ext_s <= '0;
          r_tmr_s <= '0;
        end else begin
          r_ext_s <= {r_ext_s[0], ext_irq_i};
          r_tmr_s <= {r_tmr_s[0], tmr_irq_i};
        end
      end
      assign w_meip = r_ext_s[1];
      assign w_mtip = r_tmr_s[1];
    end else begin : g_sync1
      logic r_ext_s, r_tmr_s;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_ext_s <= 1'b0;
          r_tmr_s <= 1'b0;
        end else begin
          r_ext_s <= ext_irq_i;
          r_tmr_s <= tmr_irq_i;
        end
      end
      assign w_meip = r_ext_s;
      assign w_mtip = r_tmr_s;
    end
  endgenerate

  assign w_irq_ext  = w_meip & r_meie;
  assign w_irq_pend = w_irq_ext | (w_mtip & r_mtie);
  assign w_take     = r_mstatus_mie & w_irq_pend;

`ifdef CSR_COUNTER_EN
  logic [63:0] r_mcycle, r_minstret;
  logic        w_retire;
  assign w_retire = instr_valid_i & !stall_i & (r_state == ST_RUN) & !w_trap;
`endif

  always_comb begin
    w_rdata = '0;
    case (csr_addr_i)
      A_MSTATUS: w_rdata = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mstatus_mie, 3'd0};
      A_MIE:     w_rdata = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
      A_MIP:     w_rdata = {20'd0, w_meip, 3'd0, w_mtip, 7'd0};
      A_MTVEC:   w_rdata = MTVEC_ADDR;
      A_MEPC:    w_rdata = r_mepc;
      A_MCAUSE:  w_rdata = r_mcause;
`ifdef CSR_COUNTER_EN
      12'hB00, 12'hC00: w_rdata = r_mcycle[31:0];
      12'hB80, 12'hC80: w_rdata = r_mcycle[63:32];
      12'hB02, 12'hC02: w_rdata = r_minstret[31:0];
      12'hB82, 12'hC82: w_rdata = r_minstret[63:32];
`endif
      default:   w_rdata = '0;
    endcase
  end
  assign csr_rdata_o = w_rdata;

  // Set/clear forms with a zero source must not write, so side effects stay clean.
  assign w_src = funct3_i[2] ? {27'd0, zimm_i} : rs1_data_i;
  always_comb begin
    w_wdata  = w_rdata;
    w_wr_req = 1'b0;
    case (funct3_i[1:0])
      2'b01: begin w_wdata = w_src;            w_wr_req = 1'b1;          end
      2'b10: begin w_wdata = w_rdata | w_src;  w_wr_req = (w_src != '0); end
      2'b11: begin w_wdata = w_rdata & ~w_src; w_wr_req = (w_src != '0); end
      default: begin w_wdata = w_rdata;        w_wr_req = 1'b0;          end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_trap       = 1'b0;
    w_trap_pc    = pc_i;
    w_mret       = 1'b0;
    w_wfi_enter  = 1'b0;
    w_csr_commit = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!stall_i) begin
          if (w_take & instr_valid_i) begin
            w_trap      = 1'b1;
            w_state_nxt = ST_REDIR;
          end else if (mret_i) begin
            w_mret      = 1'b1;
            w_state_nxt = ST_REDIR;
          end else if (wfi_i & !w_irq_pend) begin
            w_wfi_enter = 1'b1;
            w_state_nxt = ST_WFI_WAIT;
          end else if (csr_en_i & w_wr_req) begin
            w_csr_commit = 1'b1;
          end
        end
      end
      ST_WFI_WAIT: begin
        if (!stall_i & w_irq_pend) begin
          if (r_mstatus_mie) begin
            w_trap      = 1'b1;
            w_trap_pc   = r_wfi_pc;
            w_state_nxt = ST_REDIR;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_REDIR: begin
        if (!stall_i) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mstatus_mie <= 1'b0;
      r_mpie        <= 1'b0;
      r_meie        <= 1'b0;
      r_mtie        <= 1'b0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_wfi_pc      <= '0;
      r_redirect_pc <= '0;
    end else begin
      if (w_csr_commit) begin
        case (csr_addr_i)
          A_MSTATUS: begin r_mstatus_mie <= w_wdata[3]; r_mpie <= w_wdata[7]; end
          A_MIE:     begin r_meie <= w_wdata[11]; r_mtie <= w_wdata[7]; end
          A_MEPC:    r_mepc   <= {w_wdata[31:2], 2'b00};
          A_MCAUSE:  r_mcause <= w_wdata;
          default:   ;
        endcase
      end
      if (w_trap) begin
        r_mepc        <= {w_trap_pc[31:2], 2'b00};
        r_mcause      <= w_irq_ext ? 32'h8000_000B : 32'h8000_0007;
        r_mpie        <= r_mstatus_mie;
        r_mstatus_mie <= 1'b0;
        r_redirect_pc <= MTVEC_ADDR;
      end
      if (w_mret) begin
        r_mstatus_mie <= r_mpie;
        r_mpie        <= 1'b1;
        r_redirect_pc <= r_mepc;
      end
      if (w_wfi_enter) r_wfi_pc <= pc_i + 32'd4;
    end
  end

`ifdef CSR_COUNTER_EN
  // A CSR write to either half replaces that half and suppresses the increment for the cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_csr_commit && csr_addr_i == 12'hB00)      r_mcycle <= {r_mcycle[63:32], w_wdata};
      else if (w_csr_commit && csr_addr_i == 12'hB80) r_mcycle <= {w_wdata, r_mcycle[31:0]};
      else                                            r_mcycle <= r_mcycle + 64'd1;
      if (w_csr_commit && csr_addr_i == 12'hB02)      r_minstret <= {r_minstret[63:32], w_wdata};
      else if (w_csr_commit && csr_addr_i == 12'hB82) r_minstret <= {w_wdata, r_minstret[31:0]};
      else if (w_retire)                              r_minstret <= r_minstret + 64'd1;
    end
  end
`endif

  // redirect_o is a one-cycle strobe (longer only if stall_i holds REDIR); redirect_pc_o is meaningful only with it.
  assign redirect_o    = (r_state == ST_REDIR);
  assign redirect_pc_o = r_redirect_pc;
  assign wfi_stall_o   = (r_state == ST_WFI_WAIT);
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR ops, interrupt entry, MRET, WFI wake paths and stall freezing.
module tb_csr_trap_ctrl;
  localparam int IRQ_SYNC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, instr_valid_i, csr_en_i, mret_i, wfi_i, ext_irq_i, tmr_irq_i;
  logic [31:0] pc_i, rs1_data_i;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  zimm_i;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        redirect_o, wfi_stall_o;
  logic [1:0]  dbg_state_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] d;
  int          stall_cnt;

  csr_trap_ctrl #(.MTVEC_ADDR(32'h0001_0000), .IRQ_SYNC(IRQ_SYNC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .csr_en_i(csr_en_i), .funct3_i(funct3_i), .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i),
    .zimm_i(zimm_i), .mret_i(mret_i), .wfi_i(wfi_i), .ext_irq_i(ext_irq_i), .tmr_irq_i(tmr_irq_i),
    .csr_rdata_o(csr_rdata_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .wfi_stall_o(wfi_stall_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Every redirect pulse must match the next queued target; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (rst && redirect_o) begin
      if (exp_q.size() == 0) check("redir_unexpected", 32'(redirect_o), 32'h0);
      else check("redir_pc", redirect_pc_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid_i = 1'b0; csr_en_i = 1'b0; mret_i = 1'b0; wfi_i = 1'b0;
    funct3_i = 3'd0; rs1_data_i = '0; zimm_i = '0;
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] z, output logic [31:0] old);
    instr_valid_i = 1'b1; csr_en_i = 1'b1; funct3_i = f3; csr_addr_i = a;
    rs1_data_i = rs1; zimm_i = z;
    #1 old = csr_rdata_o;
    tick();
    idle();
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
    csr_en_i = 1'b0; csr_addr_i = a;
    #1 v = csr_rdata_o;
  endtask

  task automatic wait_redirect(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (redirect_o) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'h1);
    idle();
  endtask

  task automatic wfi_run(input logic [31:0] pc, input int raise_at, input bit use_tmr, output int cnt);
    wfi_i = 1'b1; instr_valid_i = 1'b1; pc_i = pc;
    tick();
    idle();
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (wfi_stall_o) cnt++;
      else break;
      if (k == raise_at) begin
        if (use_tmr) tmr_irq_i = 1'b1;
        else         ext_irq_i = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall_i = 1'b0; ext_irq_i = 1'b0; tmr_irq_i = 1'b0;
    pc_i = '0; csr_addr_i = '0;
    idle();
    repeat (3) tick();
    check("rst_redirect", 32'(redirect_o), 32'h0);
    check("rst_wfi_stall", 32'(wfi_stall_o), 32'h0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    rst = 1'b1;
    tick();

    read_csr(12'h300, d); check("rst_mstatus", d, 32'h0000_1800);
    read_csr(12'h304, d); check("rst_mie", d, 32'h0);
    read_csr(12'h305, d); check("rst_mtvec", d, 32'h0001_0000);
    read_csr(12'h344, d); check("rst_mip", d, 32'h0);
    read_csr(12'h341, d); check("rst_mepc", d, 32'h0);

    csr_op(3'b010, 12'h304, 32'h880, 5'd0, d); check("rs_mie_old", d, 32'h0);
    csr_op(3'b011, 12'h304, 32'h080, 5'd0, d); check("rc_mie_old", d, 32'h880);
    read_csr(12'h304, d); check("mie_after_rc", d, 32'h800);
    csr_op(3'b001, 12'h7C0, 32'hFFFF, 5'd0, d);
    read_csr(12'h7C0, d); check("unimpl_read", d, 32'h0);
    csr_op(3'b001, 12'h305, 32'h123, 5'd0, d);
    read_csr(12'h305, d); check("mtvec_ro", d, 32'h0001_0000);
    csr_op(3'b001, 12'h341, 32'h1237, 5'd0, d);
    read_csr(12'h341, d); check("mepc_align", d, 32'h1234);

    // External interrupt taken against the instruction at 0x120.
    csr_op(3'b110, 12'h300, 32'h0, 5'd8, d); check("rsi_mstatus_old", d, 32'h1800);
    read_csr(12'h300, d); check("mstatus_mie_set", d, 32'h1808);
    exp_q.push_back(32'h0001_0000);
    ext_irq_i = 1'b1; instr_valid_i = 1'b1; pc_i = 32'h120;
    wait_redirect("ext_redirect", 8);
    ext_irq_i = 1'b0;
    repeat (3) tick();
    read_csr(12'h341, d); check("ext_mepc", d, 32'h120);
    read_csr(12'h342, d); check("ext_mcause", d, 32'h8000_000B);
    read_csr(12'h300, d); check("ext_mstatus", d, 32'h1880);

    // Both sources pending: external wins; then MRET back to mepc.
    csr_op(3'b010, 12'h304, 32'h80, 5'd0, d); check("mie_set_mtie_old", d, 32'h800);
    csr_op(3'b110, 12'h300, 32'h0, 5'd8, d); check("mstatus_old2", d, 32'h1880);
    exp_q.push_back(32'h0001_0000);
    ext_irq_i = 1'b1; tmr_irq_i = 1'b1; instr_valid_i = 1'b1; pc_i = 32'h300;
    wait_redirect("both_redirect", 8);
    ext_irq_i = 1'b0; tmr_irq_i = 1'b0;
    repeat (3) tick();
    read_csr(12'h342, d); check("both_mcause", d, 32'h8000_000B);
    read_csr(12'h341, d); check("both_mepc", d, 32'h300);
    exp_q.push_back(32'h300);
    mret_i = 1'b1; instr_valid_i = 1'b1; pc_i = 32'h400;
    wait_redirect("mret_redirect", 4);
    tick();
    read_csr(12'h300, d); check("mret_mstatus", d, 32'h1888);

    // WFI woken by the timer with interrupts enabled.
    exp_q.push_back(32'h0001_0000);
    wfi_run(32'h200, 10, 1'b1, stall_cnt);
    check("wfi_stall_cycles", 32'(stall_cnt), 32'(10 + IRQ_SYNC));
    tick();
    tmr_irq_i = 1'b0;
    repeat (3) tick();
    check("wfi_redirect_done", 32'(exp_q.size()), 32'h0);
    read_csr(12'h341, d); check("wfi_mepc", d, 32'h204);
    read_csr(12'h342, d); check("wfi_mcause", d, 32'h8000_0007);
    read_csr(12'h300, d); check("wfi_mstatus", d, 32'h1880);

    // WFI with MIE=0: wakes without a redirect.
    wfi_run(32'h500, 5, 1'b0, stall_cnt);
    check("wfi_nomie_cycles", 32'(stall_cnt), 32'(5 + IRQ_SYNC));
    ext_irq_i = 1'b0;
    repeat (3) tick();
    check("wfi_nomie_state", 32'(dbg_state_o), 32'h0);
    read_csr(12'h341, d); check("wfi_nomie_mepc", d, 32'h204);
    csr_op(3'b010, 12'h300, 32'h0, 5'd0, d); check("rs_x0_old", d, 32'h1880);
    read_csr(12'h300, d); check("rs_x0_mstatus", d, 32'h1880);

    // Stalled CSR write must not commit; the unstalled immediate form must.
    stall_i = 1'b1;
    csr_op(3'b001, 12'h342, 32'hDEAD, 5'd0, d); check("stall_rdata", d, 32'h8000_0007);
    read_csr(12'h342, d); check("stall_no_write", d, 32'h8000_0007);
    stall_i = 1'b0;
    csr_op(3'b101, 12'h342, 32'h0, 5'd5, d);
    read_csr(12'h342, d); check("rwi_mcause", d, 32'h5);

    repeat (2) tick();
    check("redir_q_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
